// File: rtl/jtag_bitbang_bridge.sv
// Remote-bitbang byte stream to JTAG pin bridge.
// Pin-write commands drive TCK/TMS/TDI and optionally stall the command
// channel for HOLD_CYCLES so the SoC sees a minimum pin-state duration.
// 'R' samples TDO and returns '0'/'1' on a valid/ready response channel.
// While that response is pending, no further commands are accepted.
module jtag_bitbang_bridge #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter bit          SYNC_TDO    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       jtag_tck,
  output logic       jtag_tms,
  output logic       jtag_tdi,
  input  logic       jtag_tdo,
  output logic       jtag_trst_n,
  output logic       jtag_srst_n,
  output logic       quit_o,
  output logic       cmd_err_o
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  typedef logic [HW-1:0] hold_t;

  logic       tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic       trst_n_q, trst_n_d, srst_n_q, srst_n_d;
  logic       quit_q, quit_d, err_q, err_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  hold_t      hold_q, hold_d;
  logic       tdo_s;
  logic       acc;

  // TDO either through a 2-flop synchronizer or straight from the pad.
  if (SYNC_TDO) begin : g_sync
    logic [1:0] sync_q;
    // Two-stage metastability filter for the asynchronous TDO pad.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], jtag_tdo};
    end
    assign tdo_s = sync_q[1];
  end else begin : g_nosync
    assign tdo_s = jtag_tdo;
  end

  assign cmd_ready_o = (hold_q == '0) & ~rsp_valid_q;
  assign acc         = cmd_valid_i & cmd_ready_o;

  // Command decode and next-state for all registered outputs.
  always_comb begin
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_n_d    = trst_n_q;
    srst_n_d    = srst_n_q;
    quit_d      = quit_q;
    err_d       = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    hold_d      = (hold_q != '0) ? hold_q - hold_t'(1) : hold_q;
    if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
    if (acc) begin
      if (cmd_data_i inside {[8'h30:8'h37]}) begin
        tck_d  = cmd_data_i[2];
        tms_d  = cmd_data_i[1];
        tdi_d  = cmd_data_i[0];
        hold_d = hold_t'(HOLD_CYCLES);
      end else begin
        case (cmd_data_i)
          8'h52: begin                       // 'R'
            rsp_valid_d = 1'b1;
            rsp_data_d  = {7'h18, tdo_s};    // 0x30 + sample
          end
          8'h72: begin trst_n_d = 1'b1; srst_n_d = 1'b1; end  // 'r'
          8'h73: begin trst_n_d = 1'b1; srst_n_d = 1'b0; end  // 's'
          8'h74: begin trst_n_d = 1'b0; srst_n_d = 1'b1; end  // 't'
          8'h75: begin trst_n_d = 1'b0; srst_n_d = 1'b0; end  // 'u'
          8'h42, 8'h62: ;                    // 'B','b': blink, ignored
          8'h51: quit_d = 1'b1;              // 'Q'
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  // State registers; reset drops any pending response and hold count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_q       <= 1'b0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
      trst_n_q    <= 1'b1;
      srst_n_q    <= 1'b1;
      quit_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      hold_q      <= '0;
    end else begin
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_n_q    <= trst_n_d;
      srst_n_q    <= srst_n_d;
      quit_q      <= quit_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      hold_q      <= hold_d;
    end
  end

  assign jtag_tck    = tck_q;
  assign jtag_tms    = tms_q;
  assign jtag_tdi    = tdi_q;
  assign jtag_trst_n = trst_n_q;
  assign jtag_srst_n = srst_n_q;
  assign quit_o      = quit_q;
  assign cmd_err_o   = err_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_jtag_bitbang_bridge.sv
// Bench for jtag_bitbang_bridge: vector table for single-command effects,
// hand sequences for hold timing, response back-pressure, TDO sync latency
// and asynchronous reset.
module tb_jtag_bitbang_bridge;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       tck, tms, tdi, tdo, trst_n, srst_n, quit, err;

  int n_cmp = 0;
  int n_bad = 0;

  jtag_bitbang_bridge #(.HOLD_CYCLES(2), .SYNC_TDO(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .jtag_tck(tck), .jtag_tms(tms), .jtag_tdi(tdi), .jtag_tdo(tdo),
    .jtag_trst_n(trst_n), .jtag_srst_n(srst_n),
    .quit_o(quit), .cmd_err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] cmd;
    logic [4:0] pins;   // {tck, tms, tdi, trst_n, srst_n}
    logic       quit;
    logic       err;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called 1ns after a posedge; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] b);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: cmd_ready stuck 0 for byte 0x%0h", b);
      return;
    end
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{8'h35, 5'b10111, 1'b0, 1'b0};  // '5'
    vt[1]  = '{8'h32, 5'b01011, 1'b0, 1'b0};  // '2'
    vt[2]  = '{8'h37, 5'b11111, 1'b0, 1'b0};  // '7'
    vt[3]  = '{8'h74, 5'b11101, 1'b0, 1'b0};  // 't'
    vt[4]  = '{8'h75, 5'b11100, 1'b0, 1'b0};  // 'u'
    vt[5]  = '{8'h73, 5'b11110, 1'b0, 1'b0};  // 's'
    vt[6]  = '{8'h72, 5'b11111, 1'b0, 1'b0};  // 'r'
    vt[7]  = '{8'h30, 5'b00011, 1'b0, 1'b0};  // '0'
    vt[8]  = '{8'h42, 5'b00011, 1'b0, 1'b0};  // 'B'
    vt[9]  = '{8'h51, 5'b00011, 1'b1, 1'b0};  // 'Q'
    vt[10] = '{8'h58, 5'b00011, 1'b1, 1'b1};  // 'X'
    vt[11] = '{8'h62, 5'b00011, 1'b1, 1'b0};  // 'b'
    vt[12] = '{8'h38, 5'b00011, 1'b1, 1'b1};  // '8'
    vt[13] = '{8'h71, 5'b00011, 1'b1, 1'b1};  // 'q'

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0; tdo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pins", {tck, tms, tdi, trst_n, srst_n}, 5'b00011);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_quit_err", {quit, err}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hold timing after a pin write, and no hold after a reset-pin write.
    send(8'h35);
    chk("p5_pins", {tck, tms, tdi}, 3'b101);
    chk("hold_c0", cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("hold_c1", cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("hold_c2", cmd_ready, 1'b1);
    send(8'h32);
    chk("p2_pins", {tck, tms, tdi}, 3'b010);
    send(8'h74);
    chk("t_nohold", cmd_ready, 1'b1);
    send(8'h72);

    for (int i = 0; i < 14; i++) begin
      send(vt[i].cmd);
      chk($sformatf("vec%0d_pins", i), {tck, tms, tdi, trst_n, srst_n}, vt[i].pins);
      chk($sformatf("vec%0d_quit", i), quit, vt[i].quit);
      chk($sformatf("vec%0d_err", i), err, vt[i].err);
    end
    @(posedge clk); #1;
    chk("err_drop", err, 1'b0);
    chk("quit_sticky", quit, 1'b1);

    // 'R' with back-pressure; a pending command must not leak through.
    tdo = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(8'h52);
    chk("r1_valid", rsp_valid, 1'b1);
    chk("r1_data", rsp_data, 8'h31);
    chk("r1_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1; cmd_data = 8'h37;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("r1_hold%0d", i), {rsp_valid, rsp_data, cmd_ready}, {1'b1, 8'h31, 1'b0});
      chk($sformatf("r1_pins%0d", i), {tck, tms, tdi}, 3'b000);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("r1_taken", {rsp_valid, cmd_ready}, 2'b01);

    tdo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(8'h52);
    chk("r0", {rsp_valid, rsp_data}, {1'b1, 8'h30});
    @(posedge clk); #1;
    chk("r0_taken", rsp_valid, 1'b0);

    // TDO is only visible to 'R' two edges after it changes.
    tdo = 1'b1;
    @(posedge clk); #1;
    send(8'h52);
    chk("sync_early", rsp_data, 8'h30);
    send(8'h52);
    chk("sync_late", rsp_data, 8'h31);
    @(posedge clk); #1;

    // Async reset with a response pending.
    rsp_ready = 1'b0;
    send(8'h37);
    send(8'h75);
    send(8'h52);
    chk("pend_valid", rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_rsp", rsp_valid, 1'b0);
    chk("arst_pins", {tck, tms, tdi, trst_n, srst_n}, 5'b00011);
    chk("arst_quit", quit, 1'b0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready", cmd_ready, 1'b1);

    // Async reset mid-hold; next command accepted without waiting.
    send(8'h35);
    chk("mid_hold", cmd_ready, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("hold_cleared", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_data = 8'h32;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("post_rst_cmd", {tck, tms, tdi}, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
